aes_inv_key_sched: RTL



---
 rtl/aes_inv_key_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round key 10,
// then streams round keys 10..0 by running the key schedule backwards.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0x00 sits in the top eight bits, so the index is (255 - i_byte) * 8.
    assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [127:0] i_key_in,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    output logic [127:0] o_rk_out,
    output logic [3:0]   o_rk_round,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic         o_rk_last
);
    // state | meaning
    // IDLE  | waiting for a cipher key, key_ready high
    // FWD   | ten forward expansion steps toward round key 10
    // REV   | presenting round keys 10..0, one inverse step per handshake
    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_key_sched supports only NR=10 (AES-128)");
    end

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_last;

    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_inv0, w_inv1, w_inv2, w_inv3;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [31:0]  w_sub_in, w_rot, w_sub, w_t;
    logic [3:0]   w_rc_idx;
    logic [7:0]   w_rcon;

    assign w_k0 = r_key[127:96];
    assign w_k1 = r_key[95:64];
    assign w_k2 = r_key[63:32];
    assign w_k3 = r_key[31:0];

    assign w_inv3 = w_k3 ^ w_k2;
    assign w_inv2 = w_k2 ^ w_k1;
    assign w_inv1 = w_k1 ^ w_k0;

    // One S-box word is shared: FWD feeds the current w3, REV the recovered previous w3.
    assign w_sub_in = (r_state == REV) ? w_inv3 : w_k3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*i +: 8]),
            .o_byte (w_sub[8*i +: 8])
        );
    end

    assign w_rc_idx = (r_state == REV) ? r_round : r_cnt + 4'd1;

    always_comb begin
        w_rcon = 8'h00;
        case (w_rc_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t    = w_sub ^ {w_rcon, 24'h000000};
    assign w_inv0 = w_k0 ^ w_t;

    assign w_f0 = w_k0 ^ w_t;
    assign w_f1 = w_k1 ^ w_f0;
    assign w_f2 = w_k2 ^ w_f1;
    assign w_f3 = w_k3 ^ w_f2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_key   <= 128'd0;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_key_valid) begin
                        r_key   <= i_key_in;
                        r_cnt   <= 4'd0;
                        r_state <= FWD;
                    end
                end
                FWD: begin
                    r_key <= {w_f0, w_f1, w_f2, w_f3};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state <= REV;
                        r_round <= 4'd10;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                REV: begin
                    if (i_rk_ready) begin
                        if (r_round == 4'd0) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_key   <= {w_inv0, w_inv1, w_inv2, w_inv3};
                            r_round <= r_round - 4'd1;
                            r_last  <= (r_round == 4'd1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The working key doubles as the output register; rk_valid qualifies it.
    assign o_key_ready = (r_state == IDLE);
    assign o_rk_out    = r_key;
    assign o_rk_round  = r_round;
    assign o_rk_valid  = r_valid;
    assign o_rk_last   = r_last;
endmodule
